// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU constants for the register-file writeback path.
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : register file geometry
//   WB_SRC_*                           : requester index assignment on the arbiter
//   reg_bit()                          : one-hot decode of a register address, r0 never decodes
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int REG_DATA_W     = 32;
  localparam int NUM_REGS       = 32;

  localparam int WB_SRC_PIPE    = 0;
  localparam int WB_SRC_MULTDIV = 1;
  localparam int WB_SRC_IO      = 2;

  localparam int STARVE_CNT_W   = 4;

  // r0 is hardwired to zero, so it can never be reserved or tracked.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
    reg_bit = '0;
    if (r != '0) reg_bit[r] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search over requesters 1..NUM_REQ-1.
//   i_valid [NUM_REQ-1:1] : request vector (requester 0 is arbitrated by the caller)
//   i_ptr                 : index to start searching from, always in 1..NUM_REQ-1
//   o_grant [NUM_REQ-1:1] : one-hot grant, all zero when nothing is valid
//   o_found               : a grant was produced
module rr_priority_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:1]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:1]         o_grant,
  output logic                       o_found
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // One extra bit so ptr+offset cannot overflow before the wrap.
  logic [PTR_W:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NUM_REQ - 1; off++) begin
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(off);
      // Wrap from NUM_REQ-1 back to 1, skipping requester 0.
      if (w_idx > (PTR_W+1)'(NUM_REQ - 1)) w_idx = w_idx - (PTR_W+1)'(NUM_REQ - 1);
      if (!o_found && i_valid[w_idx[PTR_W-1:0]]) begin
        o_grant[w_idx[PTR_W-1:0]] = 1'b1;
        o_found                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between writeback sources
// (pipeline, multdiv, game I/O) and tracks destinations reserved by long-latency ops.
//   clock, reset            : clock, synchronous active-high reset
//   req_valid/req_ready     : per-requester handshake, ready is combinational
//   req_reg/req_data        : packed per-requester destination and data
//   rsv_valid/rsv_reg       : reserve a destination register
//   busy_mask               : registered bitmap of reserved registers (bit 0 always 0)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered regfile write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_reg,
  input  logic [32*NUM_REQ-1:0]   req_data,
  input  logic                    rsv_valid,
  input  logic [4:0]              rsv_reg,
  output logic [31:0]             busy_mask,
  output logic                    ctrl_writeEnable,
  output logic [4:0]              ctrl_writeReg,
  output logic [31:0]             data_writeReg
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]        r_rr_ptr;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic [NUM_REGS-1:0]     r_busy_p1;
  logic                    r_we_p1;
  logic [REG_ADDR_W-1:0]   r_wreg_p1;
  logic [REG_DATA_W-1:0]   r_wdata_p1;

  logic [NUM_REQ-1:1]      w_rr_grant;
  logic                    w_rr_found;
  logic                    w_lower_valid;
  logic                    w_starved;
  logic                    w_grant0;
  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_xfer;
  logic [PTR_W-1:0]        w_sel_idx;
  logic [REG_ADDR_W-1:0]   w_sel_reg;
  logic [REG_DATA_W-1:0]   w_sel_data;
  logic [NUM_REGS-1:0]     w_busy_next;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_valid (req_valid[NUM_REQ-1:1]),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_found (w_rr_found)
  );

  // p0: grant selection
  assign w_lower_valid = |req_valid[NUM_REQ-1:1];
  assign w_starved     = (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));
  // Pipeline writeback wins unless it has starved a waiting lower requester.
  assign w_grant0      = req_valid[WB_SRC_PIPE] && !(w_starved && w_lower_valid);

  always_comb begin
    w_grant = '0;
    if (!reset) begin
      if (w_grant0)        w_grant = NUM_REQ'(1);
      else if (w_rr_found) w_grant = {w_rr_grant, 1'b0};
    end
  end

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  always_comb begin
    w_sel_idx  = '0;
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx  = PTR_W'(i);
        w_sel_reg  = req_reg[i*REG_ADDR_W +: REG_ADDR_W];
        w_sel_data = req_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  // Clear on write first, then set on reserve, so a same-cycle reserve wins.
  always_comb begin
    w_busy_next = r_busy_p1;
    if (w_xfer)    w_busy_next = w_busy_next & ~reg_bit(w_sel_reg);
    if (rsv_valid) w_busy_next = w_busy_next | reg_bit(rsv_reg);
  end

  // p1: registered write port, scoreboard and arbitration state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr     <= PTR_W'(1);
      r_starve_cnt <= '0;
      r_busy_p1    <= '0;
      r_we_p1      <= 1'b0;
      r_wreg_p1    <= '0;
      r_wdata_p1   <= '0;
    end else begin
      r_busy_p1 <= w_busy_next;
      // A write to r0 is accepted but never reaches the regfile.
      r_we_p1   <= w_xfer && (w_sel_reg != '0);
      if (w_xfer) begin
        r_wreg_p1  <= w_sel_reg;
        r_wdata_p1 <= w_sel_data;
      end
      if (w_xfer && !w_grant[0]) begin
        r_rr_ptr     <= (w_sel_idx == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1) : w_sel_idx + PTR_W'(1);
        r_starve_cnt <= '0;
      end else if (w_grant[0] && w_lower_valid && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
      end
    end
  end

  assign busy_mask        = r_busy_p1;
  assign ctrl_writeEnable = r_we_p1;
  assign ctrl_writeReg    = r_wreg_p1;
  assign data_writeReg    = r_wdata_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int N     = 3;
  localparam int LIMIT = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_reg;
  logic [32*N-1:0] req_data;
  logic            rsv_valid;
  logic [4:0]      rsv_reg;
  logic [31:0]     busy_mask;
  logic            ctrl_writeEnable;
  logic [4:0]      ctrl_writeReg;
  logic [31:0]     data_writeReg;

  logic [4:0]      t_reg  [N];
  logic [31:0]     t_data [N];

  assign req_reg  = {t_reg[2], t_reg[1], t_reg[0]};
  assign req_data = {t_data[2], t_data[1], t_data[0]};

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .rsv_valid        (rsv_valid),
    .rsv_reg          (rsv_reg),
    .busy_mask        (busy_mask),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic rv, input logic [4:0] rr);
    req_valid = v;
    t_reg[0]  = r0;  t_reg[1]  = r1;  t_reg[2]  = r2;
    t_data[0] = d0;  t_data[1] = d1;  t_data[2] = d2;
    rsv_valid = rv;
    rsv_reg   = rr;
  endtask

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  r0, r1, r2;
    logic [31:0] d0, d1, d2;
    logic        rv;
    logic [4:0]  rr;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic rv, input logic [4:0] rr,
                     input logic [2:0] e_ready, input logic e_we, input logic [4:0] e_wreg,
                     input logic [31:0] e_wdata, input logic [31:0] e_busy);
    vec_t e;
    e.v = v; e.r0 = r0; e.r1 = r1; e.r2 = r2; e.d0 = d0; e.d1 = d1; e.d2 = d2;
    e.rv = rv; e.rr = rr; e.e_ready = e_ready; e.e_we = e_we; e.e_wreg = e_wreg;
    e.e_wdata = e_wdata; e.e_busy = e_busy;
    tbl.push_back(e);
  endtask

  // Reference model: arbitration rules applied directly with integer arithmetic.
  int          m_ptr;
  int          m_cnt;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_ptr = 1; m_cnt = 0; m_busy = 0; m_we = 0; m_wreg = 0; m_wdata = 0;
  endtask

  task automatic model_cycle(output logic [2:0] e_ready);
    int  g;
    int  cand;
    bit  lower;
    g     = -1;
    lower = (req_valid[1] || req_valid[2]);
    if (req_valid[0] && !(m_cnt >= LIMIT && lower)) g = 0;
    else begin
      for (int k = 0; k < N - 1; k++) begin
        cand = ((m_ptr - 1 + k) % (N - 1)) + 1;
        if (g < 0 && req_valid[cand]) g = cand;
      end
    end
    e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    if (g >= 0) begin
      m_we    = (t_reg[g] != 0);
      m_wreg  = t_reg[g];
      m_wdata = t_data[g];
      m_busy[t_reg[g]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (g == 0 && lower && m_cnt < LIMIT) m_cnt++;
    if (g >= 1) begin
      m_cnt = 0;
      m_ptr = (g % (N - 1)) + 1;
    end
    if (rsv_valid && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] er;
    reset = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    @(posedge clock); #1;

    // Reset held with every requester asking: nothing may be granted.
    for (int c = 0; c < 2; c++) begin
      reset = 1'b1;
      drive(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b1, 7);
      #1;
      check("reset_ready", 32'(req_ready), 32'h0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    check("post_reset_we",    32'(ctrl_writeEnable), 32'h0);
    check("post_reset_busy",  busy_mask,             32'h0);
    check("post_reset_wreg",  32'(ctrl_writeReg),    32'h0);
    check("post_reset_wdata", data_writeReg,         32'h0);

    // Directed table, expectations worked out by hand from reset state.
    add(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 1'b0, 0, 3'b001, 1'b1, 5, 32'hDEADBEEF, 0);
    add(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0, 3'b000, 1'b0, 5, 32'hDEADBEEF, 0);
    for (int i = 0; i < 2; i++) begin
      add(3'b110, 0, 1, 2, 0, 32'h11, 32'h22, 1'b0, 0, 3'b010, 1'b1, 1, 32'h11, 0);
      add(3'b110, 0, 1, 2, 0, 32'h11, 32'h22, 1'b0, 0, 3'b100, 1'b1, 2, 32'h22, 0);
    end
    add(3'b010, 0, 1, 2, 0, 32'h11, 32'h22, 1'b0, 0, 3'b010, 1'b1, 1, 32'h11, 0);
    add(3'b010, 0, 1, 2, 0, 32'h11, 32'h22, 1'b0, 0, 3'b010, 1'b1, 1, 32'h11, 0);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < LIMIT; i++)
        add(3'b011, 3, 4, 0, 32'h30, 32'h40, 0, 1'b0, 0, 3'b001, 1'b1, 3, 32'h30, 0);
      add(3'b011, 3, 4, 0, 32'h30, 32'h40, 0, 1'b0, 0, 3'b010, 1'b1, 4, 32'h40, 0);
    end
    add(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 12, 3'b000, 1'b0, 4, 32'h40, 32'h00001000);
    add(3'b010, 0, 12, 0, 0, 32'hCAFE, 0, 1'b0, 0, 3'b010, 1'b1, 12, 32'hCAFE, 0);
    add(3'b010, 0, 12, 0, 0, 32'hBEEF, 0, 1'b1, 12, 3'b010, 1'b1, 12, 32'hBEEF, 32'h00001000);
    add(3'b001, 0, 0, 0, 32'h1234, 0, 0, 1'b1, 0, 3'b001, 1'b0, 0, 32'h1234, 32'h00001000);
    add(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 12, 3'b000, 1'b0, 0, 32'h1234, 32'h00001000);
    add(3'b100, 0, 0, 12, 0, 0, 32'h77, 1'b0, 0, 3'b100, 1'b1, 12, 32'h77, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].d0, tbl[i].d1, tbl[i].d2,
            tbl[i].rv, tbl[i].rr);
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      @(posedge clock); #1;
      check($sformatf("tbl%0d_we", i),    32'(ctrl_writeEnable), 32'(tbl[i].e_we));
      check($sformatf("tbl%0d_wreg", i),  32'(ctrl_writeReg),    32'(tbl[i].e_wreg));
      check($sformatf("tbl%0d_wdata", i), data_writeReg,         tbl[i].e_wdata);
      check($sformatf("tbl%0d_busy", i),  busy_mask,             tbl[i].e_busy);
    end

    // Reset arriving while a transfer and a reservation are pending.
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5);
    @(posedge clock); #1;
    check("midrst_pre_busy", busy_mask, 32'h00000020);
    reset = 1'b1;
    drive(3'b001, 7, 0, 0, 32'h55, 0, 0, 1'b1, 9);
    #1;
    check("midrst_ready", 32'(req_ready), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    check("midrst_we",    32'(ctrl_writeEnable), 32'h0);
    check("midrst_busy",  busy_mask,             32'h0);
    check("midrst_wreg",  32'(ctrl_writeReg),    32'h0);
    check("midrst_wdata", data_writeReg,         32'h0);
    model_reset();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom_range(0, 7)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)));
      #1;
      model_cycle(er);
      check("rand_ready", 32'(req_ready), 32'(er));
      @(posedge clock); #1;
      check("rand_we",    32'(ctrl_writeEnable), 32'(m_we));
      check("rand_wreg",  32'(ctrl_writeReg),    32'(m_wreg));
      check("rand_wdata", data_writeReg,         m_wdata);
      check("rand_busy",  busy_mask,             m_busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between several writeback sources: pipeline writeback, the multdiv unit on completion, and game I/O loads (controller/timer registers). It drives ctrl_writeEnable, ctrl_writeReg and data_writeReg of regfile from a registered output stage. It also keeps a 32-bit busy scoreboard of destinations reserved by long-latency operations, which the hazard unit uses to stall readers.

Parameters:
NUM_REQ, 3, number of write requesters. Requester 0 is pipeline writeback. Legal range is 2 to 8.
STARVE_LIMIT, 4, consecutive blocked cycles after which a lower requester overrides requester 0. Legal range is 1 to 15.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant; combinational from current state and req_valid
req_reg  in  5*NUM_REQ  destination register; requester i uses bits [5i+4:5i]
req_data  in  32*NUM_REQ  write data; requester i uses bits [32i+31:32i]
rsv_valid  in  1  reserve a destination for a long-latency operation
rsv_reg  in  5  register to reserve
busy_mask  out  32  reserved-register bitmap; bit 0 is always 0
ctrl_writeEnable  out  1  to regfile write enable
ctrl_writeReg  out  5  to regfile write address
data_writeReg  out  32  to regfile write data

Behaviour:
- Reset (synchronous, overrides all other inputs):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - busy_mask=0, round-robin pointer=1, starvation counter=0.
  - req_ready is all 0 while reset is high.
- Transfer: requester i transfers in a cycle when req_valid[i] and req_ready[i] are both high. At most one req_ready bit is high per cycle. req_ready[i] is never high unless req_valid[i] is high.
- Grant selection, evaluated each cycle:
  - Normal case: if req_valid[0] is high and the starvation counter is below STARVE_LIMIT, grant requester 0.
  - Otherwise, grant the first valid requester in 1..NUM_REQ-1, searching from the round-robin pointer upward and wrapping from NUM_REQ-1 back to 1.
  - If no requester is valid, grant nothing.
- Round-robin pointer: after a grant to requester k ≥ 1, the pointer becomes k+1, wrapping to 1. A grant to requester 0 leaves the pointer unchanged.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, in each cycle where requester 0 is granted while any requester ≥1 is valid.
  - Clears to 0 on any grant to a requester ≥1.
  - Otherwise holds.
  - When it equals STARVE_LIMIT and a lower requester is valid, req_ready[0]=0 for that cycle (override).
  - If it equals STARVE_LIMIT but no lower requester is valid, requester 0 is granted and the counter holds.
- Write output (1-cycle latency):
  - On the clock edge after a transfer, ctrl_writeReg and data_writeReg take the granted req_reg and req_data.
  - ctrl_writeEnable becomes 1, except when req_reg=0: the write is accepted (ready asserted) but ctrl_writeEnable stays 0.
  - With no transfer, ctrl_writeEnable=0 and ctrl_writeReg/data_writeReg hold their previous values.
- Scoreboard (updates on the clock edge):
  - rsv_valid with rsv_reg≠0 sets busy_mask[rsv_reg].
  - A transfer to register r clears busy_mask[r], whichever requester performed it.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - Reserving an already-busy register leaves it set.
  - Reserving register 0 is ignored.
  - busy_mask is a registered output: it reflects updates one cycle after the event.
- Reset mid-operation: any pending transfer is lost, busy bits are cleared, and regfile sees no write in the cycle after reset.
- Width rules: req_reg and rsv_reg are unsigned 5-bit values. The starvation counter is 4 bits wide.

Decomposition:
- Shared package for the CPU: constants REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, and WB_SRC_PIPE=0, WB_SRC_MULTDIV=1, WB_SRC_IO=2 as the requester index assignments.
- One natural sub-module, rr_priority_picker (combinational). It takes a valid vector and a pointer and returns a one-hot grant over indices 1..NUM_REQ-1 plus a found flag.
- The scoreboard, starvation counter and output register stay in the top module.

Test Plan:
- Reset then idle: hold reset 2 cycles with all req_valid=1 → req_ready=000 during reset. After release, ctrl_writeEnable=0 and busy_mask=0.
- Single write: req_valid=001, req_reg[0]=5, req_data[0]=0xDEADBEEF → req_ready=001. Next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF. The following cycle ctrl_writeEnable=0 with reg/data held.
- Round-robin: req_valid=110 held for 4 cycles → grants go 1, 2, 1, 2. With req_valid=010, requester 1 is granted every cycle.
- Starvation (STARVE_LIMIT=4): req_valid=011 held continuously → requester 0 is granted 4 cycles, requester 1 on cycle 5, then requester 0 for the next 4 cycles, repeating.
- Scoreboard:
  - rsv_valid=1, rsv_reg=12 → busy_mask=0x00001000 next cycle.
  - Requester 1 later writes r12 → bit clears on the same edge that ctrl_writeEnable rises.
  - Reserve r12 and write r12 in the same cycle → bit remains set.
- r0 handling: write to reg 0 with data 0x1234 → req_ready=1, next cycle ctrl_writeEnable=0. rsv_reg=0 → busy_mask stays 0.
